// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a 2:1 data mux: grants one requester at a time with a bounded burst,
// and registers the selected word with a valid strobe for the downstream stage.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             Sel,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             xfer;
  logic             burst_done;

  always_comb begin
    xfer       = ((state_q == StOwn0) && req0) || ((state_q == StOwn1) && req1);
    burst_done = (cnt_q + 8'd1) == BurstMax;
    state_d    = state_q;
    cnt_d      = xfer ? cnt_q + 8'd1 : cnt_q;
    last_d     = last_q;

    case (state_q)
      StIdle: begin
        if (req0 && (!req1 || last_q)) state_d = StOwn0;
        else if (req1)                 state_d = StOwn1;
      end
      StOwn0: begin
        if (!req0)          state_d = req1 ? StOwn1 : StIdle;
        else if (burst_done) begin
          // No one waiting: keep the path but start a fresh burst.
          if (req1) state_d = StOwn1;
          else      cnt_d   = '0;
        end
      end
      StOwn1: begin
        if (!req1)          state_d = req0 ? StOwn0 : StIdle;
        else if (burst_done) begin
          if (req0) state_d = StOwn0;
          else      cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == StOwn0) last_d = 1'b0;
      if (state_d == StOwn1) last_d = 1'b1;
    end

    // Select follows the owner and holds through idle periods.
    case (state_d)
      StOwn0:  sel_d = 1'b0;
      StOwn1:  sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase

    gnt0_d  = (state_d == StOwn0);
    gnt1_d  = (state_d == StOwn1);
    valid_d = xfer;
    out_d   = xfer ? (sel_q ? D1 : D0) : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign Sel   = sel_q;
  assign valid = valid_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected words queued as stimulus is driven,
// popped by a negedge monitor whenever valid is seen.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] D0;
  logic [3:0] D1;
  logic       gnt0;
  logic       gnt1;
  logic       Sel;
  logic [3:0] out;
  logic       valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_word;

  mux_rr_arbiter #(
    .WIDTH    (4),
    .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .D0   (D0),
    .D1   (D1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .Sel  (Sel),
    .out  (out),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check_eq("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    if (valid === 1'b1) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check_eq("sb_out", 32'(out), 32'(exp_word));
      end
    end
  end

  initial begin
    logic [3:0] d1_seq [5];
    d1_seq = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0};

    // Reset with both requesting
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; D0 = 4'hA; D1 = 4'h5;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_gnt0", 32'(gnt0), 32'd0);
      check_eq("rst_gnt1", 32'(gnt1), 32'd0);
      check_eq("rst_sel", 32'(Sel), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_out", 32'(out), 32'd0);
    end
    rst = 1'b0;
    step();
    check_eq("first_gnt0", 32'(gnt0), 32'd1);
    check_eq("first_gnt1", 32'(gnt1), 32'd0);
    check_eq("first_valid", 32'(valid), 32'd0);

    // Contention: A x4, 5 x4, A x4 with no bubbles
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back((i < 4 || i >= 8) ? 4'hA : 4'h5);
      step();
      check_eq("cont_valid", 32'(valid), 32'd1);
      check_eq("cont_gnt1", 32'(gnt1), 32'(((i >= 3) && (i < 7)) || (i == 11)));
    end

    // Idle hold after OWN1 releases
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("idle_gnt0", 32'(gnt0), 32'd0);
      check_eq("idle_gnt1", 32'(gnt1), 32'd0);
      check_eq("idle_sel", 32'(Sel), 32'd1);
      check_eq("idle_valid", 32'(valid), 32'd0);
      check_eq("idle_out", 32'(out), 32'hA);
    end

    // Early release by owner 0 after two transfers
    req0 = 1'b1; req1 = 1'b1; D0 = 4'h3; D1 = 4'hC;
    step();
    check_eq("er_gnt0", 32'(gnt0), 32'd1);
    check_eq("er_sel0", 32'(Sel), 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(4'h3);
      step();
      check_eq("er_valid0", 32'(valid), 32'd1);
    end
    req0 = 1'b0;
    step();
    check_eq("er_gnt1", 32'(gnt1), 32'd1);
    check_eq("er_gnt0_off", 32'(gnt0), 32'd0);
    check_eq("er_sel1", 32'(Sel), 32'd1);
    check_eq("er_no_xfer", 32'(valid), 32'd0);
    exp_q.push_back(4'hC);
    step();
    check_eq("er_valid1", 32'(valid), 32'd1);
    req1 = 1'b0;
    step();
    check_eq("er_release", 32'(gnt1), 32'd0);
    check_eq("er_rel_valid", 32'(valid), 32'd0);

    // Single requester 1, burst limit passes without a grant gap
    req1 = 1'b1;
    step();
    check_eq("sr_gnt1", 32'(gnt1), 32'd1);
    check_eq("sr_sel", 32'(Sel), 32'd1);
    check_eq("sr_valid0", 32'(valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      D1 = d1_seq[i];
      exp_q.push_back(d1_seq[i]);
      step();
      check_eq("sr_valid", 32'(valid), 32'd1);
      check_eq("sr_gnt1_hold", 32'(gnt1), 32'd1);
    end
    req1 = 1'b0;
    step();
    check_eq("sr_idle_gnt1", 32'(gnt1), 32'd0);
    check_eq("sr_idle_out", 32'(out), 32'd0);

    // Reset in the middle of an OWN1 burst
    req1 = 1'b1; D1 = 4'h9;
    step();
    check_eq("rm_gnt1", 32'(gnt1), 32'd1);
    exp_q.push_back(4'h9);
    step();
    check_eq("rm_xfer1", 32'(valid), 32'd1);
    rst = 1'b1;
    step();
    check_eq("rm_gnt1_off", 32'(gnt1), 32'd0);
    check_eq("rm_sel", 32'(Sel), 32'd0);
    check_eq("rm_valid", 32'(valid), 32'd0);
    check_eq("rm_out", 32'(out), 32'd0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step();
    check_eq("rm_tie_gnt0", 32'(gnt0), 32'd1);
    check_eq("rm_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
